// File: rtl/axi4_slave_ram.sv
// axi4_slave_ram
//   AXI4 memory slave terminating all five channels into an on-chip RAM that
//   is addressed by DATA_WIDTH-wide words. The read and write engines are
//   independent and each handles one burst at a time. The engines support
//   FIXED, INCR and WRAP bursts of up to 256 beats, byte strobes, and SLVERR
//   responses.
// Ports:
//   aclk, areset          clock and synchronous active-high reset
//   s_axi_aw*             write address channel (id/addr/len/size/burst, handshake)
//   s_axi_w*              write data channel (data/strb/last, handshake)
//   s_axi_b*              write response channel (id/resp, handshake)
//   s_axi_ar*             read address channel (id/addr/len/size/burst, handshake)
//   s_axi_r*              read data channel (id/data/resp/last, handshake)
module axi4_slave_ram #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH:0]   MEM_BYTES   = (ADDR_WIDTH+1)'(MEM_WORDS * STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return {1'b0, addr} < MEM_BYTES;
    endfunction

    function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_WIDTH'(addr >> BYTE_SHIFT);
    endfunction

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Request-level errors: oversized beats, the reserved burst type, or an illegal wrap length.
    function automatic logic req_err(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
        return (size > 3'(BYTE_SHIFT)) || (burst == 2'b11) ||
               ((burst == 2'b10) && !wrap_len_ok(len));
    endfunction

    // An illegal-length WRAP is already flagged as an error, so it simply walks
    // forward like INCR instead of wrapping inside a non-power-of-two block.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] mask;
        step = ADDR_ONE << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_ONE) << size) - ADDR_ONE;
        case (burst)
            2'b00:   return addr;
            2'b10:   return wrap_len_ok(len) ? ((addr & ~mask) | ((addr + step) & mask))
                                             : (addr + step);
            default: return addr + step;
        endcase
    endfunction

    // ------------------------------------------------------------------ write
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    w_state_t              w_state, w_state_next;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ID_WIDTH-1:0]   w_id;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_err;
    logic                  aw_hs, w_hs, b_hs, w_last_beat, w_beat_err;

    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign b_hs        = s_axi_bvalid && s_axi_bready;
    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_err  = !in_range(w_addr) || (s_axi_wlast != w_last_beat);

    // The beat counter ends the burst. A disagreeing wlast only marks the error.
    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_next = W_RESP;
            W_RESP:  if (b_hs) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // The ready and valid outputs are registered copies of the next state.
    // The B payload is captured on the final beat so it also includes that beat's error.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= RESP_OKAY;
            w_addr        <= '0;
            w_id          <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_size        <= '0;
            w_burst       <= '0;
            w_err         <= 1'b0;
        end else begin
            w_state       <= w_state_next;
            s_axi_awready <= (w_state_next == W_IDLE);
            s_axi_wready  <= (w_state_next == W_DATA);
            s_axi_bvalid  <= (w_state_next == W_RESP);
            if (aw_hs) begin
                w_id    <= s_axi_awid;
                w_addr  <= s_axi_awaddr;
                w_len   <= s_axi_awlen;
                w_size  <= s_axi_awsize;
                w_burst <= s_axi_awburst;
                w_cnt   <= '0;
                w_err   <= req_err(s_axi_awlen, s_axi_awsize, s_axi_awburst);
            end
            if (w_hs) begin
                w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                w_cnt  <= w_cnt + 8'd1;
                if (w_beat_err) w_err <= 1'b1;
                if (w_last_beat) begin
                    s_axi_bid   <= w_id;
                    s_axi_bresp <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // RAM byte writes. Out-of-range beats do not alias into the array, and a beat
    // that coincides with reset is discarded.
    always_ff @(posedge aclk) begin
        if (!areset && w_hs && in_range(w_addr)) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------- read
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    r_state_t              r_state, r_state_next;
    logic [ADDR_WIDTH-1:0] r_addr, fetch_addr;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_err, ar_err, fetch_err;
    logic                  ar_hs, r_hs;

    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign r_hs   = s_axi_rvalid && s_axi_rready;
    assign ar_err = req_err(s_axi_arlen, s_axi_arsize, s_axi_arburst);

    // r_addr always holds the address of the next beat to present.
    // In idle the first fetch comes directly from the AR channel, so there is one read port.
    always_comb begin
        r_state_next = r_state;
        fetch_addr   = r_addr;
        fetch_err    = r_err;
        case (r_state)
            R_IDLE: begin
                fetch_addr = s_axi_araddr;
                fetch_err  = ar_err;
                if (ar_hs) r_state_next = R_DATA;
            end
            R_DATA: if (r_hs && s_axi_rlast) r_state_next = R_IDLE;
        endcase
    end

    // Beats are fetched on the AR handshake and on each non-final R handshake.
    // The fetch reads the array with a non-blocking access, so a same-cycle write
    // to the same word returns the old data.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rlast   <= 1'b0;
            r_addr        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= r_state_next;
            s_axi_arready <= (r_state_next == R_IDLE);
            s_axi_rvalid  <= (r_state_next == R_DATA);
            if (ar_hs) begin
                s_axi_rid   <= s_axi_arid;
                s_axi_rlast <= (s_axi_arlen == 8'd0);
                r_addr      <= next_addr(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
                r_len       <= s_axi_arlen;
                r_size      <= s_axi_arsize;
                r_burst     <= s_axi_arburst;
                r_err       <= ar_err;
                r_cnt       <= '0;
            end else if (r_hs && !s_axi_rlast) begin
                s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
                r_addr      <= next_addr(r_addr, r_len, r_size, r_burst);
                r_cnt       <= r_cnt + 8'd1;
            end
            if (ar_hs || (r_hs && !s_axi_rlast)) begin
                s_axi_rdata <= in_range(fetch_addr) ? mem[word_idx(fetch_addr)] : '0;
                s_axi_rresp <= (fetch_err || !in_range(fetch_addr)) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end
endmodule

// File: tb/tb_axi4_slave_ram.sv
// tb_axi4_slave_ram
//   Directed self-checking bench for axi4_slave_ram with default parameters
//   (32-bit data, 1024-word RAM). Expected values are hand-computed constants.
module tb_axi4_slave_ram;
    logic        aclk;
    logic        areset;
    logic [3:0]  s_axi_awid;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    int total;
    int bad;

    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];

    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic        b_prompt;
    int          stalls;

    axi4_slave_ram dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    // 100 MHz clock.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Hard stop in case a handshake bug stalls the sequence outside a bounded wait.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic timeoutFail(input string tag);
        total++;
        bad++;
        $error("[TB] FAIL %s: observed=timeout expected=handshake", tag);
    endtask

    // All drive and sample points sit 1 ns after a rising edge.
    task automatic sendAw(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst);
        int n;
        n = 0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = 3'd2; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        while (!s_axi_awready && n < 20) begin @(posedge aclk); #1; n++; end
        if (n >= 20) timeoutFail("aw_wait");
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic sendW(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n;
        n = 0;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
        while (!s_axi_wready && n < 20) begin @(posedge aclk); #1; n++; end
        if (n >= 20) timeoutFail("w_wait");
        @(posedge aclk); #1;
        s_axi_wvalid = 1'b0;
    endtask

    task automatic takeB(output logic [1:0] resp, output logic [3:0] id);
        int n;
        n = 0;
        s_axi_bready = 1'b1;
        while (!s_axi_bvalid && n < 20) begin @(posedge aclk); #1; n++; end
        if (n >= 20) timeoutFail("b_wait");
        resp = s_axi_bresp;
        id   = s_axi_bid;
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic writeBurst(input logic [3:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [1:0] burst,
                              output logic [1:0] resp, output logic [3:0] bid_seen,
                              output logic prompt);
        sendAw(id, addr, len, burst);
        for (int i = 0; i <= int'(len); i++) sendW(wr_data[i], wr_strb[i], i == int'(len));
        prompt = s_axi_bvalid;
        takeB(resp, bid_seen);
    endtask

    task automatic sendAr(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst);
        int n;
        n = 0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = 3'd2; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 20) begin @(posedge aclk); #1; n++; end
        if (n >= 20) timeoutFail("ar_wait");
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    // rready is held high for the whole burst. Cycles spent waiting for rvalid are
    // summed into stall_cnt.
    task automatic readBurst(input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [1:0] burst,
                             output int stall_cnt);
        int n;
        stall_cnt = 0;
        sendAr(id, addr, len, burst);
        s_axi_rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!s_axi_rvalid && n < 20) begin @(posedge aclk); #1; n++; end
            if (n >= 20) timeoutFail("r_wait");
            stall_cnt += n;
            rd_data[i] = s_axi_rdata;
            rd_resp[i] = s_axi_rresp;
            rd_last[i] = s_axi_rlast;
            rd_id[i]   = s_axi_rid;
            @(posedge aclk); #1;
        end
        s_axi_rready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        areset = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;

        // Step 1: outputs held low in reset, and both readies rise once reset is released.
        repeat (2) @(posedge aclk);
        #1;
        checkOutput("rst_awready", s_axi_awready, 0);
        checkOutput("rst_arready", s_axi_arready, 0);
        checkOutput("rst_wready", s_axi_wready, 0);
        checkOutput("rst_bvalid", s_axi_bvalid, 0);
        checkOutput("rst_rvalid", s_axi_rvalid, 0);
        areset = 1'b0;
        @(posedge aclk); #1;
        checkOutput("post_rst_awready", s_axi_awready, 1);
        checkOutput("post_rst_arready", s_axi_arready, 1);

        // Step 2: single write of 0xDEADBEEF at 0x10, then read it back.
        wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
        writeBurst(4'h3, 32'h10, 8'd0, 2'b01, b_resp, b_id, b_prompt);
        checkOutput("single_b_prompt", b_prompt, 1);
        checkOutput("single_bresp", b_resp, 2'b00);
        checkOutput("single_bid", b_id, 4'h3);
        readBurst(4'h5, 32'h10, 8'd0, 2'b01, stalls);
        checkOutput("single_rdata", rd_data[0], 32'hDEADBEEF);
        checkOutput("single_rlast", rd_last[0], 1);
        checkOutput("single_rresp", rd_resp[0], 2'b00);
        checkOutput("single_rid", rd_id[0], 4'h5);
        checkOutput("single_rvalid_drop", s_axi_rvalid, 0);

        // Step 3: INCR write len=3 at 0x100 with data 1..4, then read back-to-back.
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
        writeBurst(4'h1, 32'h100, 8'd3, 2'b01, b_resp, b_id, b_prompt);
        checkOutput("incr_bresp", b_resp, 2'b00);
        readBurst(4'h2, 32'h100, 8'd3, 2'b01, stalls);
        checkOutput("incr_stalls", 64'(stalls), 0);
        checkOutput("incr_d0", rd_data[0], 32'd1);
        checkOutput("incr_d1", rd_data[1], 32'd2);
        checkOutput("incr_d2", rd_data[2], 32'd3);
        checkOutput("incr_d3", rd_data[3], 32'd4);
        checkOutput("incr_last0", rd_last[0], 0);
        checkOutput("incr_last2", rd_last[2], 0);
        checkOutput("incr_last3", rd_last[3], 1);

        // Step 4: a WRAP read of len=3 at 0x108 wraps inside 0x100..0x10F and returns 3,4,1,2.
        readBurst(4'h6, 32'h108, 8'd3, 2'b10, stalls);
        checkOutput("wrap_d0", rd_data[0], 32'd3);
        checkOutput("wrap_d1", rd_data[1], 32'd4);
        checkOutput("wrap_d2", rd_data[2], 32'd1);
        checkOutput("wrap_d3", rd_data[3], 32'd2);
        checkOutput("wrap_resp3", rd_resp[3], 2'b00);
        checkOutput("wrap_last3", rd_last[3], 1);

        // Step 5: partial strobe. Write 0xFFFFFFFF, then clear bytes 0 and 2.
        wr_data[0] = 32'hFFFFFFFF; wr_strb[0] = 4'hF;
        writeBurst(4'h0, 32'h20, 8'd0, 2'b01, b_resp, b_id, b_prompt);
        wr_data[0] = 32'h00000000; wr_strb[0] = 4'h5;
        writeBurst(4'h0, 32'h20, 8'd0, 2'b01, b_resp, b_id, b_prompt);
        readBurst(4'h0, 32'h20, 8'd0, 2'b01, stalls);
        checkOutput("strobe_rdata", rd_data[0], 32'hFF00FF00);

        // Step 6: an out-of-range write must not alias word 0, and a read straddles the top.
        wr_data[0] = 32'hA5A5A5A5; wr_strb[0] = 4'hF;
        writeBurst(4'h0, 32'h0, 8'd0, 2'b01, b_resp, b_id, b_prompt);
        wr_data[0] = 32'hCAFEF00D;
        writeBurst(4'h0, 32'hFFC, 8'd0, 2'b01, b_resp, b_id, b_prompt);
        wr_data[0] = 32'h12345678;
        writeBurst(4'h9, 32'h1000, 8'd0, 2'b01, b_resp, b_id, b_prompt);
        checkOutput("oob_bresp", b_resp, 2'b10);
        checkOutput("oob_bid", b_id, 4'h9);
        readBurst(4'h0, 32'h0, 8'd0, 2'b01, stalls);
        checkOutput("oob_no_alias", rd_data[0], 32'hA5A5A5A5);
        readBurst(4'hA, 32'hFFC, 8'd1, 2'b01, stalls);
        checkOutput("top_d0", rd_data[0], 32'hCAFEF00D);
        checkOutput("top_resp0", rd_resp[0], 2'b00);
        checkOutput("top_last0", rd_last[0], 0);
        checkOutput("top_d1", rd_data[1], 32'h0);
        checkOutput("top_resp1", rd_resp[1], 2'b10);
        checkOutput("top_last1", rd_last[1], 1);

        // Step 7: reset in the middle of an 8-beat write and a stalled read.
        sendAw(4'h7, 32'h200, 8'd7, 2'b01);
        for (int i = 0; i < 3; i++) sendW(32'h50 + 32'(i), 4'hF, 1'b0);
        sendAr(4'h8, 32'h100, 8'd3, 2'b01);
        checkOutput("mid_rvalid", s_axi_rvalid, 1);
        checkOutput("mid_wready", s_axi_wready, 1);
        areset = 1'b1;
        @(posedge aclk); #1;
        checkOutput("midrst_rvalid", s_axi_rvalid, 0);
        checkOutput("midrst_bvalid", s_axi_bvalid, 0);
        checkOutput("midrst_wready", s_axi_wready, 0);
        areset = 1'b0;
        @(posedge aclk); #1;
        checkOutput("rel_awready", s_axi_awready, 1);
        checkOutput("rel_arready", s_axi_arready, 1);
        checkOutput("rel_bvalid", s_axi_bvalid, 0);
        checkOutput("rel_rvalid", s_axi_rvalid, 0);
        wr_data[0] = 32'h0BADCAFE; wr_strb[0] = 4'hF;
        writeBurst(4'hC, 32'h30, 8'd0, 2'b01, b_resp, b_id, b_prompt);
        checkOutput("fresh_bresp", b_resp, 2'b00);
        checkOutput("fresh_bid", b_id, 4'hC);
        readBurst(4'hD, 32'h30, 8'd0, 2'b01, stalls);
        checkOutput("fresh_rdata", rd_data[0], 32'h0BADCAFE);
        checkOutput("fresh_rid", rd_id[0], 4'hD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi4_slave_ram.md
Name: axi4_slave_ram

Overview:
- AXI4 memory slave sitting directly downstream of axi4_master. It terminates all five AXI channels into an on-chip word-addressed RAM.
- Serves as the bench and SoC target for master bring-up.
- Independent read and write engines, each with one outstanding burst.
- Supports FIXED/INCR/WRAP bursts up to 256 beats, byte strobes, and SLVERR signalling.

Parameters:
- ADDR_WIDTH, 32, address width in bits.
- DATA_WIDTH, 32, data bus width in bits; must be 32 or 64.
- ID_WIDTH, 4, transaction ID width.
- MEM_WORDS, 1024, RAM depth in DATA_WIDTH words; power of two.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axi_awid  in  ID_WIDTH  write ID.
- s_axi_awaddr  in  ADDR_WIDTH  write start byte address.
- s_axi_awlen  in  8  beats minus 1.
- s_axi_awsize  in  3  bytes per beat, log2.
- s_axi_awburst  in  2  burst type: 0 FIXED, 1 INCR, 2 WRAP.
- s_axi_awvalid  in  1 / s_axi_awready  out  1  AW handshake.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  DATA_WIDTH/8  byte enables.
- s_axi_wlast  in  1  last write beat.
- s_axi_wvalid  in  1 / s_axi_wready  out  1  W handshake.
- s_axi_bid  out  ID_WIDTH  response ID.
- s_axi_bresp  out  2  write response: 0 OKAY, 2 SLVERR.
- s_axi_bvalid  out  1 / s_axi_bready  in  1  B handshake.
- s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst  in  (same widths as AW)  read request.
- s_axi_arvalid  in  1 / s_axi_arready  out  1  AR handshake.
- s_axi_rid  out  ID_WIDTH  read ID.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rlast  out  1  last read beat.
- s_axi_rvalid  out  1 / s_axi_rready  in  1  R handshake.

Behaviour:
- Reset (areset=1 at a clock edge):
  - All outputs go to 0; both FSMs go to IDLE; any burst in flight is abandoned with no response.
  - RAM contents are not cleared.
  - awready and arready go to 1 in the first cycle after reset deasserts.
- All outputs are registered. Channel handshakes follow standard AXI4 rules: a transfer occurs on a cycle with valid && ready high; once asserted, bvalid/rvalid and their payload hold until accepted.
- Address and word index:
  - Word index = (addr >> log2(DATA_WIDTH/8)) mod MEM_WORDS.
  - A beat is in range when addr < MEM_WORDS*DATA_WIDTH/8.
- Next-beat address:
  - FIXED: unchanged.
  - INCR: addr + 2^size.
  - WRAP: increment within the aligned block of (len+1)*2^size bytes, wrapping to the block base.
- Error conditions (each sets the burst's error flag):
  - Any out-of-range beat.
  - size > log2(DATA_WIDTH/8).
  - Reserved burst type 3; the burst is then treated as INCR.
  - WRAP with len not in {1,3,7,15}.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/size/burst, clear the beat counter and error flag, go to W_DATA.
  - W_DATA: wready=1. Each accepted beat writes bytes where wstrb=1 (in range only) and advances address and counter. A wlast value that disagrees with (counter==len) sets the error flag. After accepting beat len, go to W_RESP. Bursts always end on the beat count, never on wlast.
  - W_RESP: bvalid=1, bid=latched ID, bresp=SLVERR if error flag set else OKAY. On bready, go to W_IDLE.
  - Minimum throughput: AW cycle, one cycle per beat, then B (bvalid registered, valid in the cycle after the last W handshake).
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch the request and go to R_DATA.
  - R_DATA: rvalid rises in the cycle after the AR handshake, carrying beat 0.
    - rid = latched ID.
    - rdata = RAM word, or 0 for an out-of-range beat.
    - rresp = SLVERR for an out-of-range beat or a request-level error, else OKAY.
    - rlast = 1 on beat len.
    - On an R handshake the next beat is presented on the following cycle, so a held rready gives 1 beat/cycle.
    - The handshake on the rlast beat returns the FSM to R_IDLE with rvalid=0.
- Concurrency:
  - Read and write engines run fully in parallel.
  - A same-cycle read fetch and write to the same word returns the old data (read-before-write).
  - No ordering is guaranteed between a read and a write.
- Write data beats are not accepted before the AW handshake; wready=0 in W_IDLE.

Test Plan:
- Single write of 0xDEADBEEF at addr 0x10 with wstrb=0xF, then read of 0x10 -> bresp=OKAY; rdata=0xDEADBEEF, rlast=1, rresp=OKAY, rid equals arid.
- INCR write len=3 at 0x100 with data 1,2,3,4, then INCR read len=3 with rready held -> 4 back-to-back beats reading 1,2,3,4, rlast only on beat 3.
- Partial strobe: write 0xFFFFFFFF, then 0x00000000 with wstrb=0x5 -> read returns 0xFF00FF00.
- WRAP read len=3 at 0x108 after the previous INCR setup -> beat order reads 0x108, 0x10C, 0x100, 0x104, i.e. data 3,4,1,2.
- Write at addr MEM_WORDS*4, plus a read len=1 straddling the top address -> bresp=SLVERR with RAM unchanged; read beat 0 OKAY, beat 1 SLVERR with rdata=0.
- areset pulsed mid-way through an 8-beat write and mid-way through a read -> next cycle all valids=0 and no B issued; after release awready=arready=1; a fresh transaction completes normally.
